// File: rtl/coord_step_pkg.sv
// Shared types and defaults for the coordinate step controller.
package coord_step_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, DONE} step_state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_TICK_DIV = 4;
  localparam int MAX_STEPS    = 1 << DEF_WIDTH;
endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter; expire is high while the count reads 1.
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] val,
  output logic       expire
);
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)              r_cnt <= 8'd0;
    else if (load)          r_cnt <= val;
    else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end

  assign expire = (r_cnt == 8'd1);
endmodule

// File: rtl/coord_step_ctrl.sv
// Drives a loadable up/down counter's UP/DW/LD until its Q matches a latched target.
// Pulses are registered so they appear in the cycle after the state decision.
module coord_step_ctrl
  import coord_step_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             load_mode,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cur_coord,
  output logic             up,
  output logic             dw,
  output logic             ld,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [WIDTH:0] LP_MAX_STEPS = (WIDTH+1)'(1) << WIDTH;
  localparam logic [7:0]     LP_TICK      = 8'(TICK_DIV);

  step_state_t      r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH:0]   r_step_cnt;
  logic             r_last_ld;
  logic             r_up, r_dw, r_ld, r_done, r_err;
  logic             w_tmr_load;
  logic             w_expire;

  // The settle window starts in the same cycle the pulse is on the wire.
  assign w_tmr_load = (r_state == LOAD) || (r_state == STEP);

  settle_timer u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_tmr_load),
    .val    (LP_TICK),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tgt      <= '0;
      r_step_cnt <= '0;
      r_last_ld  <= 1'b0;
      r_up       <= 1'b0;
      r_dw       <= 1'b0;
      r_ld       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_dw   <= 1'b0;
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_tgt      <= target;
            r_err      <= 1'b0;
            r_step_cnt <= '0;
            r_last_ld  <= load_mode;
            if (load_mode) begin
              r_state <= LOAD;
              r_ld    <= 1'b1;
            end else if (target == cur_coord) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= STEP;
              r_up    <= (target > cur_coord);
              r_dw    <= (target < cur_coord);
            end
          end
        end
        LOAD: r_state <= SETTLE;
        STEP: begin
          r_step_cnt <= r_step_cnt + 1'b1;
          r_state    <= SETTLE;
        end
        SETTLE: begin
          if (w_expire) begin
            if (cur_coord == r_tgt) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (r_step_cnt == LP_MAX_STEPS || r_last_ld) begin
              // Exhausted step budget or a load that did not take: give up.
              r_err   <= 1'b1;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= STEP;
              r_up    <= (r_tgt > cur_coord);
              r_dw    <= (r_tgt < cur_coord);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up   = r_up;
  assign dw   = r_dw;
  assign ld   = r_ld;
  assign d    = r_tgt;
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign err  = r_err;
endmodule

// File: tb/tb_coord_step_ctrl.sv
// Directed bench for coord_step_ctrl against a behavioural up/down/load counter.
module tb_coord_step_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       load_mode;
  logic [7:0] target;
  logic [7:0] cur_coord;
  logic       up, dw, ld, busy, done, err;
  logic [7:0] d;

  logic [7:0] cnt_q;
  logic       preset_en;
  logic [7:0] preset_val;
  logic       stuck;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_up, m_dw, m_ld, m_done_c, m_first, m_gap_bad, m_excl_bad, m_busy_bad;
  logic       m_err, m_busy_after;
  logic [7:0] m_d_ld;

  always #5 clk = ~clk;

  coord_step_ctrl #(.WIDTH(8), .TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .load_mode (load_mode),
    .target    (target),
    .cur_coord (cur_coord),
    .up        (up),
    .dw        (dw),
    .ld        (ld),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always_ff @(posedge clk) begin
    if (preset_en)  cnt_q <= preset_val;
    else if (ld)    cnt_q <= d;
    else if (up)    cnt_q <= cnt_q + 8'd1;
    else if (dw)    cnt_q <= cnt_q - 8'd1;
  end

  assign cur_coord = stuck ? 8'd0 : cnt_q;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cur(input logic [7:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    @(posedge clk); #1;
    preset_en  = 1'b0;
  endtask

  // Issues one request and observes every cycle until done (c=1 is cycle k+1).
  task automatic run_move(input logic [7:0] tgt, input logic lm, input int inject_c);
    int c, last_p;
    m_up = 0; m_dw = 0; m_ld = 0; m_done_c = -1; m_first = -1;
    m_gap_bad = 0; m_excl_bad = 0; m_busy_bad = 0; m_err = 1'bx; m_d_ld = 8'h00;
    last_p = -1;
    go = 1'b1; target = tgt; load_mode = lm;
    @(posedge clk); #1;
    go = 1'b0; target = 8'h77; load_mode = ~lm;
    c = 1;
    while (m_done_c < 0 && c < 3000) begin
      go = (c == inject_c);
      if (c == inject_c) target = 8'd50;
      if (int'(up) + int'(dw) + int'(ld) > 1) m_excl_bad++;
      if (up || dw || ld) begin
        if (m_first < 0) m_first = c;
        else if (c - last_p != 5) m_gap_bad++;
        last_p = c;
      end
      if (up) m_up++;
      if (dw) m_dw++;
      if (ld) begin m_ld++; m_d_ld = d; end
      if (!busy) m_busy_bad++;
      if (done) begin m_done_c = c; m_err = err; end
      @(posedge clk); #1;
      c++;
    end
    go = 1'b0;
    m_busy_after = busy;
  endtask

  initial begin
    int c;
    reset = 1'b1; go = 1'b0; load_mode = 1'b0; target = 8'd0;
    preset_en = 1'b0; preset_val = 8'd0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up",   up,   0);
    chk("rst_dw",   dw,   0);
    chk("rst_ld",   ld,   0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err,  0);
    chk("rst_d",    d,    0);
    reset = 1'b0;

    set_cur(8'd3);
    run_move(8'd8, 1'b0, 0);
    chk("up_n_up",  m_up, 5);
    chk("up_n_dw",  m_dw, 0);
    chk("up_n_ld",  m_ld, 0);
    chk("up_first", m_first, 1);
    chk("up_gap",   m_gap_bad, 0);
    chk("up_done",  m_done_c, 26);
    chk("up_err",   m_err, 0);
    chk("up_busy",  m_busy_bad, 0);
    chk("up_idle",  m_busy_after, 0);
    chk("up_q",     cnt_q, 8);

    set_cur(8'd200);
    run_move(8'd197, 1'b0, 0);
    chk("dn_n_dw", m_dw, 3);
    chk("dn_n_up", m_up, 0);
    chk("dn_gap",  m_gap_bad, 0);
    chk("dn_done", m_done_c, 16);
    chk("dn_q",    cnt_q, 197);

    set_cur(8'd0);
    run_move(8'hA5, 1'b1, 0);
    chk("ld_n_ld", m_ld, 1);
    chk("ld_n_st", m_up + m_dw, 0);
    chk("ld_first", m_first, 1);
    chk("ld_d",    m_d_ld, 8'hA5);
    chk("ld_done", m_done_c, 6);
    chk("ld_err",  m_err, 0);
    chk("ld_q",    cnt_q, 8'hA5);

    set_cur(8'd8);
    run_move(8'd8, 1'b0, 0);
    chk("zd_pulses", m_up + m_dw + m_ld, 0);
    chk("zd_done",   m_done_c, 1);
    chk("zd_idle",   m_busy_after, 0);

    set_cur(8'd10);
    run_move(8'd20, 1'b0, 8);
    chk("bz_n_up", m_up, 10);
    chk("bz_n_dw", m_dw, 0);
    chk("bz_done", m_done_c, 51);
    chk("bz_q",    cnt_q, 20);
    chk("bz_excl", m_excl_bad, 0);

    set_cur(8'd10);
    go = 1'b1; target = 8'd20; load_mode = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      if (up) c++;
      if (c == 3) break;
      @(posedge clk); #1;
    end
    chk("rs_third", c, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rs_up",   up,   0);
    chk("rs_busy", busy, 0);
    chk("rs_d",    d,    0);
    chk("rs_done", done, 0);
    reset = 1'b0;

    stuck = 1'b1;
    run_move(8'd1, 1'b0, 0);
    chk("st_n_up", m_up, 256);
    chk("st_gap",  m_gap_bad, 0);
    chk("st_done", m_done_c, 1281);
    chk("st_err",  m_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("st_sticky", err, 1);
    run_move(8'd0, 1'b0, 0);
    chk("st_clr_done", m_done_c, 1);
    chk("st_clr_err",  m_err, 0);
    chk("st_clr_now",  err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
